debounce_pulse: RTL
===================

Name: debounce_pulse

Overview:
- Upstream stage for the 8-bit JK-based counter. It turns a raw, bouncing push-button into a clean, single-cycle count pulse.
- `Enable` drives the counter's `Enable` input directly and shares the counter's `Clock`.
- While the button is held, optional auto-repeat emits further pulses at a fixed rate.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples needed to accept a press or a release. Must be ≥2.
- HOLD_CYCLES, 64: cycles in HELD before auto-repeat starts. Must be ≥2.
- REPEAT_CYCLES, 16: period between auto-repeat pulses. Must be ≥2.
- CNT_W, 8: internal timer width. Must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- Clock, in, 1: single system clock; all state updates on its rising edge.
- Reset, in, 1: synchronous, active-low. 0 at a rising edge resets everything.
- Button, in, 1: raw asynchronous button level; 1 = pressed.
- RepeatEn, in, 1: 1 = auto-repeat allowed; sampled every cycle.
- Enable, out, 1: one-cycle pulse per accepted press and per repeat tick.
- Stable, out, 1: debounced button level.
- Repeating, out, 1: high while the FSM is in REPEAT.

Behaviour:
- **Synchronizer:** two flip-flops, s1 then s2. The FSM uses only s2. Adds 2 cycles of latency.
- **Reset** (Reset=0 at an edge): s1=s2=0, state=IDLE, timer=0, Enable=0, Stable=0, Repeating=0. Reset overrides every other input.
- **Outputs are registered.** Enable is asserted on the edge where a pulse condition is met and deasserts on the next edge.
- **FSM states:** IDLE, PRESS_CHK, HELD, REPEAT, RELEASE_CHK.
- **IDLE** (Stable=0):
  - s2=1 → PRESS_CHK, timer=0.
- **PRESS_CHK** (Stable=0):
  - s2=0 → IDLE (bounce rejected, no pulse).
  - s2=1 and timer==DEBOUNCE_CYCLES-1 → HELD, timer=0, Stable=1, Enable=1.
  - Otherwise timer+1.
- **HELD** (Stable=1):
  - s2=0 → RELEASE_CHK, timer=0.
  - RepeatEn=1 and timer==HOLD_CYCLES-1 → REPEAT, timer=0, Enable=1, Repeating=1.
  - RepeatEn=0 → timer holds at 0; no pulses.
  - Otherwise timer+1.
- **REPEAT** (Stable=1, Repeating=1):
  - s2=0 → RELEASE_CHK, timer=0, Repeating=0.
  - RepeatEn=0 → HELD, timer=0, Repeating=0.
  - timer==REPEAT_CYCLES-1 → Enable=1, timer=0.
  - Otherwise timer+1.
- **RELEASE_CHK** (Stable=1):
  - s2=1 → HELD, timer=0, no pulse (release bounce rejected).
  - s2=0 and timer==DEBOUNCE_CYCLES-1 → IDLE, Stable=0.
  - Otherwise timer+1.
- **Press latency:** let edge k be the first edge where s1 samples Button=1, with Button held high. Then Enable is high for exactly the cycle after edge k+DEBOUNCE_CYCLES+2.
- **Pulse count:** at most one Enable per accepted press, plus repeat ticks. Enable is never high for two consecutive cycles.
- **Priority within one cycle:** Reset > s2 change > timer expiry.
- **Timer:** never wraps; it is cleared on every state change.
- **Reset mid-press:** if Button is still high after Reset returns to 1, the press is re-debounced from IDLE and produces exactly one new Enable.

Test Plan:
- **Reset:** D=4, H=8, R=3. Hold Reset=0 for 3 cycles with Button=1 → Enable=Stable=Repeating=0 throughout. Release Reset → first Enable pulse 2+4 edges after the first edge where s1 samples 1.
- **Clean press, RepeatEn=0:** Button 0→1 sampled at edge 10 and held 40 cycles → single Enable after edge 16. Stable=1 from edge 16. Stable=0 4+2 edges after the release is synchronized.
- **Bounce rejection:** Button toggles 1,0,1,0 every cycle, then stays 1 → no pulse during bounce. Exactly one Enable, 6 edges after the final sustained rise is sampled. A 3-cycle glitch (shorter than D) → no pulse, Stable stays 0.
- **Auto-repeat, RepeatEn=1:** HELD entered at edge h → Enable at h, then at h+8, h+11, h+14 while held. Repeating=1 from h+8. Release → Repeating=0, no further pulses.
- **Release bounce:** while HELD, a 2-cycle low glitch → no new Enable, Stable stays 1, hold timer restarts.
- **End-to-end with the counter:** drive the 8-bit counter with Enable. 300 presses (RepeatEn=0) → counter value 300 mod 256 = 44.

Source files
------------

// File: rtl/debounce_pulse_if.sv
// rtl/debounce_pulse_if.sv - button-side signal bundle for debounce_pulse
// Purpose: groups the raw button inputs and the cleaned pulse/level outputs.
// Signals:
//   Button    - raw asynchronous button level, 1 = pressed
//   RepeatEn  - 1 = auto-repeat allowed while held
//   Enable    - one-cycle count pulse per accepted press and per repeat tick
//   Stable    - debounced button level
//   Repeating - high while auto-repeat is active
// Modports: master drives Button/RepeatEn, slave (the debouncer) drives the rest.
interface debounce_pulse_if;
    logic Button;
    logic RepeatEn;
    logic Enable;
    logic Stable;
    logic Repeating;

    modport master (
        output Button,
        output RepeatEn,
        input  Enable,
        input  Stable,
        input  Repeating
    );

    modport slave (
        input  Button,
        input  RepeatEn,
        output Enable,
        output Stable,
        output Repeating
    );
endinterface

// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - push-button debouncer with single-cycle count pulse and auto-repeat
// Purpose: synchronises a raw button, debounces press and release, emits one
// Enable pulse per accepted press plus optional auto-repeat ticks while held.
// Ports:
//   Clock - system clock, rising edge
//   Reset - synchronous active-low reset
//   bus   - debounce_pulse_if.slave (Button, RepeatEn in; Enable, Stable, Repeating out)
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int CNT_W           = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    debounce_pulse_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_CHK   = 3'd1,
        HELD        = 3'd2,
        REPEAT      = 3'd3,
        RELEASE_CHK = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             s1;
    logic             s2;
    logic             enable_q;
    logic             stable_q;
    logic             repeating_q;
    logic             enable_next;
    logic             stable_next;
    logic             repeating_next;

    // State, timer, synchroniser and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            timer       <= '0;
            enable_q    <= 1'b0;
            stable_q    <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            s1          <= bus.Button;
            s2          <= s1;
            state       <= state_next;
            timer       <= timer_next;
            enable_q    <= enable_next;
            stable_q    <= stable_next;
            repeating_q <= repeating_next;
        end
    end

    // Next state and timer. A change on s2 is tested before timer expiry so a
    // level change always wins over a pending pulse in the same cycle.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = PRESS_CHK;
                    timer_next = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == DEB_LAST) begin
                    state_next = HELD;
                    timer_next = '0;
                end else begin
                    timer_next = timer + ONE;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_next = RELEASE_CHK;
                    timer_next = '0;
                end else if (!bus.RepeatEn) begin
                    // Hold time only accumulates while repeat is allowed.
                    timer_next = '0;
                end else if (timer == HOLD_LAST) begin
                    state_next = REPEAT;
                    timer_next = '0;
                end else begin
                    timer_next = timer + ONE;
                end
            end
            REPEAT: begin
                if (!s2) begin
                    state_next = RELEASE_CHK;
                    timer_next = '0;
                end else if (!bus.RepeatEn) begin
                    state_next = HELD;
                    timer_next = '0;
                end else if (timer == REP_LAST) begin
                    timer_next = '0;
                end else begin
                    timer_next = timer + ONE;
                end
            end
            RELEASE_CHK: begin
                if (s2) begin
                    // Release bounce: back to HELD with a fresh hold timer.
                    state_next = HELD;
                    timer_next = '0;
                end else if (timer == DEB_LAST) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + ONE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Output values loaded into the output registers on the coming edge.
    always_comb begin
        enable_next    = 1'b0;
        stable_next    = 1'b0;
        repeating_next = 1'b0;
        case (state)
            PRESS_CHK: enable_next = s2 && (timer == DEB_LAST);
            HELD:      enable_next = s2 && bus.RepeatEn && (timer == HOLD_LAST);
            REPEAT:    enable_next = s2 && bus.RepeatEn && (timer == REP_LAST);
            default:   enable_next = 1'b0;
        endcase
        stable_next    = (state_next == HELD) || (state_next == REPEAT) ||
                         (state_next == RELEASE_CHK);
        repeating_next = (state_next == REPEAT);
    end

    assign bus.Enable    = enable_q;
    assign bus.Stable    = stable_q;
    assign bus.Repeating = repeating_q;

endmodule
